// File: rtl/branch_predictor.sv
// Fetch-stage branch predictor: direct-mapped BTB with a 2-bit saturating
// direction counter per entry, trained from EX, plus branch/mispredict counters.
module branch_predictor #(
    parameter int ENTRIES = 16,
    parameter int PC_W    = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [PC_W-1:0] F_pc,
    output logic            F_predictTaken,
    output logic [PC_W-1:0] F_predictTarget,
    input  logic [PC_W-1:0] E_pc,
    input  logic [PC_W-1:0] E_target,
    input  logic            E_taken,
    input  logic [1:0]      E_updateEnable,
    input  logic            E_wrongBranch,
    output logic [31:0]     branchCount,
    output logic [31:0]     mispredictCount
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = PC_W - IDX_W - 2;

    logic             valid_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [PC_W-1:0]  target_q [ENTRIES];
    logic             is_jal_q [ENTRIES];
    logic [1:0]       ctr_q    [ENTRIES];
    logic [31:0]      branch_count_q;
    logic [31:0]      mispredict_count_q;

    logic [IDX_W-1:0] f_idx;
    logic [TAG_W-1:0] f_tag;
    logic             f_hit;
    logic [IDX_W-1:0] e_idx;
    logic [TAG_W-1:0] e_tag;
    logic             e_hit;
    logic             upd_branch;
    logic             upd_jal;
    logic             unused_pc_bits;

    // Byte-offset bits never reach the index or tag.
    assign unused_pc_bits = ^{F_pc[1:0], E_pc[1:0]};

    assign f_idx = F_pc[IDX_W+1:2];
    assign f_tag = F_pc[PC_W-1:IDX_W+2];
    assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);

    assign e_idx = E_pc[IDX_W+1:2];
    assign e_tag = E_pc[PC_W-1:IDX_W+2];
    assign e_hit = valid_q[e_idx] && (tag_q[e_idx] == e_tag);

    assign upd_branch = (E_updateEnable == 2'b10);
    assign upd_jal    = (E_updateEnable == 2'b01);

    always_comb begin
        F_predictTaken  = 1'b0;
        F_predictTarget = '0;
        if (f_hit && (is_jal_q[f_idx] || ctr_q[f_idx][1])) begin
            F_predictTaken  = 1'b1;
            F_predictTarget = target_q[f_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                is_jal_q[i] <= 1'b0;
                ctr_q[i]    <= 2'd0;
            end
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else begin
            if (upd_jal) begin
                valid_q[e_idx]  <= 1'b1;
                tag_q[e_idx]    <= e_tag;
                target_q[e_idx] <= E_target;
                is_jal_q[e_idx] <= 1'b1;
                ctr_q[e_idx]    <= 2'd3;
            end else if (upd_branch) begin
                if (e_hit) begin
                    if (E_taken) begin
                        target_q[e_idx] <= E_target;
                        if (ctr_q[e_idx] != 2'd3) ctr_q[e_idx] <= ctr_q[e_idx] + 2'd1;
                    end else if (ctr_q[e_idx] != 2'd0) begin
                        ctr_q[e_idx] <= ctr_q[e_idx] - 2'd1;
                    end
                end else if (E_taken) begin
                    // A taken miss evicts whatever aliased into this slot.
                    valid_q[e_idx]  <= 1'b1;
                    tag_q[e_idx]    <= e_tag;
                    target_q[e_idx] <= E_target;
                    is_jal_q[e_idx] <= 1'b0;
                    ctr_q[e_idx]    <= 2'd2;
                end
            end
            if (upd_jal || upd_branch) begin
                branch_count_q <= branch_count_q + 32'd1;
                if (E_wrongBranch) mispredict_count_q <= mispredict_count_q + 32'd1;
            end
        end
    end

    assign branchCount     = branch_count_q;
    assign mispredictCount = mispredict_count_q;
endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed vector table, hand-written corner
// sequences, and randomized traffic against a behavioural BTB model.
module tb_branch_predictor;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] F_pc = '0;
    logic        F_predictTaken;
    logic [31:0] F_predictTarget;
    logic [31:0] E_pc = '0;
    logic [31:0] E_target = '0;
    logic        E_taken = 1'b0;
    logic [1:0]  E_updateEnable = 2'b00;
    logic        E_wrongBranch = 1'b0;
    logic [31:0] branchCount;
    logic [31:0] mispredictCount;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_bc = '0;
    logic [31:0] exp_mc = '0;

    branch_predictor #(.ENTRIES(16), .PC_W(32)) dut (
        .clk(clk), .rst(rst), .F_pc(F_pc),
        .F_predictTaken(F_predictTaken), .F_predictTarget(F_predictTarget),
        .E_pc(E_pc), .E_target(E_target), .E_taken(E_taken),
        .E_updateEnable(E_updateEnable), .E_wrongBranch(E_wrongBranch),
        .branchCount(branchCount), .mispredictCount(mispredictCount)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  upd;
        logic [31:0] e_pc;
        logic [31:0] e_tgt;
        logic        taken;
        logic        wrong;
        logic [31:0] f_pc;
        logic        exp_tk;
        logic [31:0] exp_tgt;
    } vec_t;

    vec_t vecs[$];

    // Behavioural model: one record per slot, slot = (pc/4) mod 16, tag = pc/64.
    logic        m_valid  [16];
    logic [31:0] m_tag    [16];
    logic [31:0] m_target [16];
    logic        m_jal    [16];
    int          m_ctr    [16];

    function automatic vec_t mk(logic [1:0] upd, logic [31:0] e_pc, logic [31:0] e_tgt,
                                logic taken, logic wrong, logic [31:0] f_pc,
                                logic exp_tk, logic [31:0] exp_tgt);
        vec_t v;
        v.upd = upd; v.e_pc = e_pc; v.e_tgt = e_tgt; v.taken = taken; v.wrong = wrong;
        v.f_pc = f_pc; v.exp_tk = exp_tk; v.exp_tgt = exp_tgt;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        E_updateEnable = 2'b00;
        @(posedge clk);
        #1 rst = 1'b1;
        exp_bc = '0;
        exp_mc = '0;
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0; m_tag[i] = '0; m_target[i] = '0; m_jal[i] = 1'b0; m_ctr[i] = 0;
        end
    endtask

    task automatic apply_vec(vec_t v, int n);
        @(negedge clk);
        E_updateEnable = v.upd; E_pc = v.e_pc; E_target = v.e_tgt;
        E_taken = v.taken; E_wrongBranch = v.wrong; F_pc = v.f_pc;
        @(posedge clk);
        if (v.upd == 2'b10 || v.upd == 2'b01) begin
            exp_bc++;
            if (v.wrong) exp_mc++;
        end
        #1 E_updateEnable = 2'b00; E_wrongBranch = 1'b0;
        #1;
        check($sformatf("vec%0d_taken", n), {31'd0, F_predictTaken}, {31'd0, v.exp_tk});
        check($sformatf("vec%0d_target", n), F_predictTarget, v.exp_tgt);
    endtask

    function automatic int slot(logic [31:0] pc);
        return int'((pc / 4) % 16);
    endfunction

    task automatic model_update(logic [1:0] upd, logic [31:0] pc, logic [31:0] tgt,
                                logic taken, logic wrong);
        int s;
        logic hit;
        s = slot(pc);
        hit = m_valid[s] && (m_tag[s] == pc / 64);
        if (upd == 2'b01) begin
            m_valid[s] = 1'b1; m_tag[s] = pc / 64; m_target[s] = tgt; m_jal[s] = 1'b1; m_ctr[s] = 3;
        end else if (upd == 2'b10) begin
            if (hit && taken) begin
                m_ctr[s] = (m_ctr[s] + 1 > 3) ? 3 : m_ctr[s] + 1;
                m_target[s] = tgt;
            end else if (hit) begin
                m_ctr[s] = (m_ctr[s] - 1 < 0) ? 0 : m_ctr[s] - 1;
            end else if (taken) begin
                m_valid[s] = 1'b1; m_tag[s] = pc / 64; m_target[s] = tgt; m_jal[s] = 1'b0; m_ctr[s] = 2;
            end
        end
        if (upd == 2'b01 || upd == 2'b10) begin
            exp_bc++;
            if (wrong) exp_mc++;
        end
    endtask

    initial begin
        logic        m_tk;
        logic [31:0] m_tg;
        int          s;
        logic [1:0]  ru;
        logic [31:0] rpc, rtg;
        logic        rtk, rwr;

        vecs.push_back(mk(2'b00, 32'h000, 32'h000, 0, 0, 32'h100, 0, 32'h000));
        vecs.push_back(mk(2'b10, 32'h100, 32'h200, 1, 1, 32'h100, 1, 32'h200));
        vecs.push_back(mk(2'b10, 32'h100, 32'h000, 0, 1, 32'h100, 0, 32'h000));
        vecs.push_back(mk(2'b10, 32'h100, 32'h200, 1, 0, 32'h100, 1, 32'h200));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(2'b10, 32'h100, 32'h200, 1, 0, 32'h100, 1, 32'h200));
        vecs.push_back(mk(2'b10, 32'h100, 32'h000, 0, 0, 32'h100, 1, 32'h200));
        vecs.push_back(mk(2'b10, 32'h100, 32'h000, 0, 0, 32'h100, 0, 32'h000));
        vecs.push_back(mk(2'b10, 32'h100, 32'h000, 0, 0, 32'h100, 0, 32'h000));
        vecs.push_back(mk(2'b10, 32'h100, 32'h000, 0, 0, 32'h100, 0, 32'h000));
        vecs.push_back(mk(2'b10, 32'h100, 32'h204, 1, 0, 32'h100, 0, 32'h000));
        vecs.push_back(mk(2'b10, 32'h100, 32'h204, 1, 0, 32'h100, 1, 32'h204));
        vecs.push_back(mk(2'b01, 32'h040, 32'h080, 0, 0, 32'h040, 1, 32'h080));
        vecs.push_back(mk(2'b10, 32'h040, 32'h000, 0, 0, 32'h040, 1, 32'h080));
        vecs.push_back(mk(2'b10, 32'h040, 32'h000, 0, 0, 32'h040, 1, 32'h080));
        vecs.push_back(mk(2'b10, 32'h140, 32'h300, 1, 0, 32'h100, 0, 32'h000));
        vecs.push_back(mk(2'b00, 32'h000, 32'h000, 0, 1, 32'h140, 1, 32'h300));
        vecs.push_back(mk(2'b10, 32'h180, 32'h000, 0, 0, 32'h140, 1, 32'h300));
        vecs.push_back(mk(2'b10, 32'h180, 32'h000, 0, 0, 32'h180, 0, 32'h000));
        vecs.push_back(mk(2'b11, 32'h500, 32'h600, 1, 1, 32'h500, 0, 32'h000));
        vecs.push_back(mk(2'b00, 32'h000, 32'h000, 0, 0, 32'h143, 1, 32'h300));

        do_reset();
        F_pc = 32'h100;
        #1;
        check("reset_taken", {31'd0, F_predictTaken}, 32'd0);
        check("reset_target", F_predictTarget, 32'd0);
        check("reset_branchCount", branchCount, 32'd0);
        check("reset_mispredictCount", mispredictCount, 32'd0);

        for (int i = 0; i < vecs.size(); i++) apply_vec(vecs[i], i);
        check("vec_branchCount", branchCount, exp_bc);
        check("vec_mispredictCount", mispredictCount, exp_mc);

        // Same-cycle read/write of one slot: lookup sees the old contents.
        @(negedge clk);
        F_pc = 32'h700; E_pc = 32'h700; E_target = 32'h740; E_taken = 1'b1;
        E_updateEnable = 2'b10; E_wrongBranch = 1'b0;
        #1;
        check("bypass_pre_taken", {31'd0, F_predictTaken}, 32'd0);
        @(posedge clk);
        #1 E_updateEnable = 2'b00;
        #1;
        check("bypass_post_taken", {31'd0, F_predictTaken}, 32'd1);
        check("bypass_post_target", F_predictTarget, 32'h740);

        // Reset during an update discards it along with all prior training.
        @(negedge clk);
        rst = 1'b0; F_pc = 32'h140; E_pc = 32'h140; E_target = 32'h900;
        E_taken = 1'b1; E_updateEnable = 2'b10; E_wrongBranch = 1'b1;
        @(posedge clk);
        #1 rst = 1'b1; E_updateEnable = 2'b00; E_wrongBranch = 1'b0;
        #1;
        check("rst_upd_taken", {31'd0, F_predictTaken}, 32'd0);
        check("rst_upd_target", F_predictTarget, 32'd0);
        check("rst_upd_branchCount", branchCount, 32'd0);
        check("rst_upd_mispredictCount", mispredictCount, 32'd0);
        F_pc = 32'h700;
        #1;
        check("rst_upd_old_entry", {31'd0, F_predictTaken}, 32'd0);

        // Ten updates with three mispredicts, plus a stray wrongBranch on a bubble.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            E_pc = 32'h1000 + 32'(i * 4); E_target = 32'h2000; E_taken = i[0];
            E_updateEnable = (i % 2 == 0) ? 2'b10 : 2'b01;
            E_wrongBranch = (i == 1 || i == 4 || i == 8);
            @(posedge clk);
        end
        @(negedge clk);
        E_updateEnable = 2'b00; E_wrongBranch = 1'b1;
        @(posedge clk);
        #1 E_wrongBranch = 1'b0;
        check("perf_branchCount", branchCount, 32'd10);
        check("perf_mispredictCount", mispredictCount, 32'd3);

        // Randomized traffic against the model; lookup checked before each edge.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rpc = ($urandom_range(0, 95) << 2) | $urandom_range(0, 3);
            F_pc = ($urandom_range(0, 95) << 2) | $urandom_range(0, 3);
            rtg = $urandom & 32'hFFFF_FFFC;
            rtk = $urandom_range(0, 1);
            rwr = $urandom_range(0, 1);
            ru  = 2'($urandom_range(0, 3));
            E_pc = rpc; E_target = rtg; E_taken = rtk; E_updateEnable = ru; E_wrongBranch = rwr;
            #1;
            s = slot(F_pc);
            m_tk = m_valid[s] && (m_tag[s] == F_pc / 64) && (m_jal[s] || m_ctr[s] >= 2);
            m_tg = m_tk ? m_target[s] : 32'd0;
            check("rand_taken", {31'd0, F_predictTaken}, {31'd0, m_tk});
            check("rand_target", F_predictTarget, m_tg);
            @(posedge clk);
            model_update(ru, rpc, rtg, rtk, rwr);
            if (c % 500 == 499) begin
                #1;
                check("rand_branchCount", branchCount, exp_bc);
                check("rand_mispredictCount", mispredictCount, exp_mc);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/branch_predictor.md
# branch_predictor

IF-stage branch predictor: a direct-mapped branch target buffer (BTB) with a 2-bit saturating counter per entry. It sits upstream of the EX-stage control, in the fetch stage. It predicts taken/target for the current fetch PC and supplies `F_predictTaken`, which the pipeline carries forward as `E_PredictTaken`. It is trained from EX using the resolved branch outcome and the update class `E_updateEnable`, and it keeps branch and mispredict performance counters.

## Interface
Parameters:
- `ENTRIES`, 16: number of BTB entries; power of two, at least 2. `IDX_W = log2(ENTRIES)`.
- `PC_W`, 32: PC and target width.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  one clock; reset is synchronous and active-low.
- `F_pc`  in  PC_W  current fetch PC.
- `F_predictTaken`  out  1  prediction for `F_pc`: 1 = redirect fetch.
- `F_predictTarget`  out  PC_W  predicted target; 0 when `F_predictTaken` = 0.
- `E_pc`  in  PC_W  PC of the instruction in EX.
- `E_target`  in  PC_W  resolved jump/branch target of the EX instruction.
- `E_taken`  in  1  resolved direction (the EX `jb` signal).
- `E_updateEnable`  in  2  `10` = conditional branch, `01` = JAL, `00` = no update, `11` = treated as `00`.
- `E_wrongBranch`  in  1  EX mispredict flag.
- `branchCount`  out  32  number of resolved updates (`10` or `01`).
- `mispredictCount`  out  32  number of updates with `E_wrongBranch` = 1.

## Operation
- Index is `pc[IDX_W+1:2]`; tag is `pc[PC_W-1:IDX_W+2]`. PC bits [1:0] are ignored.
- Each entry holds: `valid`, `tag`, `target[PC_W-1:0]`, `isJal`, `ctr[1:0]`.
- Lookup is combinational from registered table state:
  - hit = `valid` && tag match.
  - `F_predictTaken` = hit && (`isJal` || `ctr[1]`).
  - `F_predictTarget` = stored target when `F_predictTaken` = 1, else 0.
- Update with `E_updateEnable` = `10` (branch), keyed by `E_pc`:
  - Hit, taken: `ctr` = min(`ctr`+1, 3); `target` = `E_target`.
  - Hit, not taken: `ctr` = max(`ctr`-1, 0); `target` unchanged.
  - Miss, taken: allocate or overwrite the entry: `valid`=1, new tag, `target`=`E_target`, `isJal`=0, `ctr`=2.
  - Miss, not taken: no write.
- Update with `E_updateEnable` = `01` (JAL): write the entry unconditionally: `valid`=1, tag, `target`=`E_target`, `isJal`=1, `ctr`=3. `E_taken` is ignored.
- JALR is never entered; EX reports JALR with update class `00`.
- Perf counters:
  - `branchCount` += 1 on any update cycle (`10` or `01`).
  - `mispredictCount` += 1 when an update cycle has `E_wrongBranch` = 1.
  - Both wrap modulo 2^32.
  - `E_wrongBranch` on a non-update cycle is ignored.
- Pipeline stalls are not inputs. EX bubbles arrive with update class `00` and therefore cause no update.

## Timing
- Lookup latency is 0 cycles (combinational from `F_pc`). An update becomes visible to lookup in the cycle after the clock edge that writes it.
- Same-cycle read/write of one index: lookup returns the pre-update contents. There is no write-through bypass.
- Only one update per cycle; the EX stage guarantees this.
- Reset (`rst` = 0 at a rising edge):
  - All `valid` bits, `ctr`, `isJal`, `target`, and both perf counters clear to 0.
  - `F_predictTaken` = 0 and `F_predictTarget` = 0 from the cycle after the edge.
  - Reset overrides any coincident update. Asserting reset mid-operation discards all training.
- Counter saturation: `ctr` never goes above 3 or below 0.
- Aliasing: a tag mismatch on a taken branch or a JAL evicts the resident entry. A tag mismatch on a not-taken branch leaves the resident entry intact.

## Test plan
- Reset, then `F_pc`=0x100 → `F_predictTaken`=0, `F_predictTarget`=0, `branchCount`=0.
- Branch update at `E_pc`=0x100, taken, target 0x200 → next cycle `F_pc`=0x100 gives taken, 0x200. Then one not-taken update → `ctr`=1 and prediction 0. Then one taken update → prediction 1 again.
- Four taken updates, then one not-taken → `ctr`=2, still predicts taken. Then two more not-taken → `ctr`=0; a further not-taken update keeps `ctr` at 0 (saturation).
- JAL update at 0x40, target 0x80 → predicts taken 0x80. Then a not-taken branch update at the same PC → `ctr` drops but prediction stays taken because `isJal`=1 keeps it.
- With `ENTRIES`=16: taken update at 0x100, then a taken update at 0x140 (same index, different tag) → 0x100 now misses and 0x140 hits. A not-taken update at 0x180 leaves the 0x140 entry intact.
- Ten updates, three with `E_wrongBranch`=1, plus one `E_wrongBranch` pulse with update `00` → `branchCount`=10, `mispredictCount`=3. Preload counters to 0xFFFFFFFF and apply one update → counter wraps to 0. Assert `rst` during an update → the table stays cleared.
